brick_scan_ctrl: RTL
====================

// Module: brick_scan_ctrl
// PURPOSE
//  Per-frame scheduler for the brick field: walks the brick descriptor RAM once per frame_tick,
//  tests each live brick against the ball's next position, retires at most one brick per scan,
//  erases it through the shared VGA plot port and pulses bounce flags to the ball mover.
//  Owns the alive bitmap and the RAM read address; sits between brick RAM, ball logic and plotter.
// PARAMETERS
//  NUM_BRICKS   40     descriptor entries in RAM, addresses 0..NUM_BRICKS-1
//  ADDR_W       6      RAM address width, 2**ADDR_W >= NUM_BRICKS
//  ERASE_COLOR  3'b000 colour written over a retired brick
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high; restores all bricks and returns to IDLE
//  frame_tick   in   1   one-cycle pulse requesting a scan
//  ball_x       in   8   ball X, sampled at scan start
//  ball_y       in   7   ball Y, sampled at scan start
//  vx, vy       in   3   velocity: bit2 = sign (1 = negative), bits1:0 = magnitude
//  rd_addr      out  ADDR_W  brick RAM address; rd_data valid exactly 1 cycle later
//  rd_data      in   22  {x[7:0], y[6:0], w[3:0], h[2:0]}
//  draw_req     out  1   pixel write request to plot port
//  draw_x/y     out  8/7 pixel coordinate, stable while draw_req && !draw_ack
//  draw_color   out  3   pixel colour
//  draw_ack     in   1   plot port accepts pixel in same cycle as draw_req
//  bounce_x/y   out  1   one-cycle pulses at scan end when the hit reflects X / Y velocity
//  busy         out  1   high in every state except IDLE
//  bricks_left  out  6   count of live bricks; all_clear out 1 = (bricks_left == 0)
// BEHAVIOUR
//  Reset values: rd_addr=0, draw_req=0, draw_x/y=0, draw_color=ERASE_COLOR, bounce_x/y=0,
//   busy=0, alive = all ones, bricks_left=NUM_BRICKS, all_clear=0 (subject to CONFIGURATION).
//  FSM: IDLE -> FETCH -> WAIT -> CHECK -> (next addr: FETCH | last: ERASE if hit else DONE);
//   ERASE -> DONE -> IDLE. FETCH drives rd_addr; WAIT covers RAM latency; CHECK evaluates rd_data.
//  Next position: nx = ball_x +/- vx[1:0], ny = ball_y +/- vy[1:0] in 9-bit signed arithmetic;
//   nx<0, nx>255, ny<0 or ny>127 -> no hit for any brick this scan.
//  Hit: alive[a] && x<=nx<=x+w && y<=ny<=y+h (inclusive; bounds computed 9 bits, no wrap).
//  First hit in address order wins; later hits in same scan ignored; scan still completes.
//  Axis: ball_x in [x,x+w] -> bounce_y; else ball_y in [y,y+h] -> bounce_x; else both (corner).
//  On hit: alive[a] cleared and bricks_left decremented in CHECK cycle; hit rect latched.
//  ERASE: raster over (w+1)*(h+1) pixels, column-fastest, draw_x=x+wc, draw_y=y+hc;
//   advance only on draw_req && draw_ack; draw_req deasserts cycle after last accepted pixel.
//  DONE: bounce pulses asserted for exactly this one cycle, then IDLE.
//  frame_tick while busy: latched into a single pending flag; scan restarts from IDLE next
//   cycle; further ticks while pending are dropped. tick while all_clear: ignored.
//  Reset mid-scan/mid-erase: draw_req low next cycle, no bounce pulse, alive restored.
//  Dead brick: never hit, never redrawn; velocity 0/0 tests current position.
// CONFIGURATION
//  INIT_PAINT_EN defined: after reset FSM enters PAINT, drawing every brick (same raster and
//   handshake) in colour from address bits {a[2:0]} | 3'b001 (never black), then IDLE;
//   busy=1 and frame_tick latched as pending during PAINT.
//  Undefined: reset goes straight to IDLE; brick field painting is owned elsewhere.
// STRUCTURE
//  brick_pkg: field widths, descriptor unpack function, FSM state enum, ERASE_COLOR default.
//  Sub-module rect_painter: start/x/y/w/h/color in, drives draw_* handshake, done pulse;
//   shared by ERASE and PAINT. Collision compare stays in this module.
// TESTING
//  T1 reset, tick, ball (5,5) v=+1/+1, no brick near -> busy 124 cycles-ish, no bounce, left=40.
//  T2 brick0 {x=20,y=10,w=7,h=3}, ball (20,8) vy=+2 -> bounce_y only, 32 pixels erased
//     at (20..27,10..13) colour 000, bricks_left=39, alive[0]=0.
//  T3 same brick, ball (18,11) vx=+2 -> bounce_x only; ball (18,8) vx=+2 vy=+2 -> both.
//  T4 draw_ack held low 10 cycles mid-erase -> draw_x/y/req stable, no pixel skipped/duplicated.
//  T5 overlapping bricks 3 and 7 both hit -> only brick 3 retired; repeat tick -> brick 7 retired.
//  T6 reset asserted mid-erase -> draw_req 0 next cycle, no bounce, bricks_left=40;
//     tick during busy -> exactly one extra scan; ball (254,5) vx=+3 -> no hit.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared widths, descriptor layout, FSM states and default erase colour for the brick scan controller.
package brick_pkg;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int W_W     = 4;
  localparam int H_W     = 3;
  localparam int DESC_W  = X_W + Y_W + W_W + H_W;
  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] ERASE_COLOR_DEF = 3'b000;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [W_W-1:0] w;
    logic [H_W-1:0] h;
  } brick_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_ERASE, S_DONE, S_PFETCH, S_PWAIT, S_PAINT
  } state_t;

  function automatic brick_t unpack_brick(input logic [DESC_W-1:0] d);
    brick_t b;
    b.x = d[21:14];
    b.y = d[13:7];
    b.w = d[6:3];
    b.h = d[2:0];
    return b;
  endfunction
endpackage

// File: rtl/brick_scan_ctrl_rect_painter.sv
// Rectangle rasteriser: walks (w+1)*(h+1) pixels column-fastest over a req/ack plot port, pulses done.
module rect_painter
  import brick_pkg::*;
#(
  parameter logic [COLOR_W-1:0] RESET_COLOR = ERASE_COLOR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [W_W-1:0]     w,
  input  logic [H_W-1:0]     h,
  input  logic [COLOR_W-1:0] color,
  input  logic               draw_ack,
  output logic               draw_req,
  output logic [X_W-1:0]     draw_x,
  output logic [Y_W-1:0]     draw_y,
  output logic [COLOR_W-1:0] draw_color,
  output logic               done
);
  logic               active_q, active_d;
  brick_t             rect_q, rect_d;
  logic [W_W-1:0]     wc_q, wc_d;
  logic [H_W-1:0]     hc_q, hc_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_q, done_d;

  always_comb begin
    active_d = active_q;
    rect_d   = rect_q;
    wc_d     = wc_q;
    hc_d     = hc_q;
    color_d  = color_q;
    done_d   = 1'b0;
    if (start) begin
      active_d = 1'b1;
      rect_d   = {x, y, w, h};
      wc_d     = '0;
      hc_d     = '0;
      color_d  = color;
    end else if (active_q && draw_ack) begin
      if (wc_q == rect_q.w) begin
        wc_d = '0;
        if (hc_q == rect_q.h) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end else begin
        wc_d = wc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      rect_q   <= '0;
      wc_q     <= '0;
      hc_q     <= '0;
      color_q  <= RESET_COLOR;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      rect_q   <= rect_d;
      wc_q     <= wc_d;
      hc_q     <= hc_d;
      color_q  <= color_d;
      done_q   <= done_d;
    end
  end

  // Coordinates come straight from flops, so they hold steady while the port stalls.
  assign draw_req   = active_q;
  assign draw_x     = rect_q.x + {{(X_W-W_W){1'b0}}, wc_q};
  assign draw_y     = rect_q.y + {{(Y_W-H_W){1'b0}}, hc_q};
  assign draw_color = color_q;
  assign done       = done_q;
endmodule

// File: rtl/brick_scan_ctrl.sv
// Per-frame brick collision scheduler: scans descriptors, retires the first hit brick, erases it, pulses bounces.
// Optional INIT_PAINT_EN: paint the whole field after reset before accepting scans.
module brick_scan_ctrl
  import brick_pkg::*;
#(
  parameter int                 NUM_BRICKS  = 40,
  parameter int                 ADDR_W      = 6,
  parameter logic [COLOR_W-1:0] ERASE_COLOR = ERASE_COLOR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     ball_x,
  input  logic [Y_W-1:0]     ball_y,
  input  logic [2:0]         vx,
  input  logic [2:0]         vy,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DESC_W-1:0]  rd_data,
  output logic               draw_req,
  output logic [X_W-1:0]     draw_x,
  output logic [Y_W-1:0]     draw_y,
  output logic [COLOR_W-1:0] draw_color,
  input  logic               draw_ack,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic               busy,
  output logic [5:0]         bricks_left,
  output logic               all_clear
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BRICKS - 1);
`ifdef INIT_PAINT_EN
  localparam state_t RST_STATE = S_PFETCH;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_BRICKS-1:0] alive_q, alive_d;
  logic [5:0]            left_q, left_d;
  logic                  pend_q, pend_d;
  logic [X_W-1:0]        bx_q, bx_d, nx_q, nx_d;
  logic [Y_W-1:0]        by_q, by_d, ny_q, ny_d;
  logic                  oob_q, oob_d;
  logic                  found_q, found_d;
  brick_t                hrect_q, hrect_d;
  logic                  hbx_q, hbx_d, hby_q, hby_d;

  logic                  paint_start, paint_done;
  brick_t                paint_rect;
  logic [COLOR_W-1:0]    paint_color;
  brick_t                desc;
  logic [9:0]            nx_u, ny_u;
  logic [8:0]            x_lo, x_hi, y_lo, y_hi, nx9, ny9, bx9, by9;
  logic                  hit, cur_in_x, cur_in_y;

  // Negative results wrap to >= 512 in 10 bits, so one upper-bound test catches both edges.
  assign nx_u = vx[2] ? ({2'b00, ball_x} - {8'b0, vx[1:0]}) : ({2'b00, ball_x} + {8'b0, vx[1:0]});
  assign ny_u = vy[2] ? ({3'b000, ball_y} - {8'b0, vy[1:0]}) : ({3'b000, ball_y} + {8'b0, vy[1:0]});

  assign desc     = unpack_brick(rd_data);
  assign x_lo     = {1'b0, desc.x};
  assign x_hi     = x_lo + {5'b0, desc.w};
  assign y_lo     = {2'b0, desc.y};
  assign y_hi     = y_lo + {6'b0, desc.h};
  assign nx9      = {1'b0, nx_q};
  assign ny9      = {2'b0, ny_q};
  assign bx9      = {1'b0, bx_q};
  assign by9      = {2'b0, by_q};
  assign hit      = alive_q[addr_q] && !oob_q && (nx9 >= x_lo) && (nx9 <= x_hi) &&
                    (ny9 >= y_lo) && (ny9 <= y_hi);
  assign cur_in_x = (bx9 >= x_lo) && (bx9 <= x_hi);
  assign cur_in_y = (by9 >= y_lo) && (by9 <= y_hi);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    alive_d     = alive_q;
    left_d      = left_q;
    pend_d      = pend_q;
    bx_d        = bx_q;
    by_d        = by_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    oob_d       = oob_q;
    found_d     = found_q;
    hrect_d     = hrect_q;
    hbx_d       = hbx_q;
    hby_d       = hby_q;
    paint_start = 1'b0;
    paint_rect  = hrect_q;
    paint_color = ERASE_COLOR;
    if (state_q != S_IDLE && frame_tick) pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (left_q == 6'd0) begin
          pend_d = 1'b0;
        end else if (frame_tick || pend_q) begin
          pend_d  = 1'b0;
          state_d = S_FETCH;
          addr_d  = '0;
          found_d = 1'b0;
          hbx_d   = 1'b0;
          hby_d   = 1'b0;
          bx_d    = ball_x;
          by_d    = ball_y;
          nx_d    = nx_u[X_W-1:0];
          ny_d    = ny_u[Y_W-1:0];
          oob_d   = (nx_u > 10'd255) || (ny_u > 10'd127);
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (hit && !found_q) begin
          found_d         = 1'b1;
          alive_d[addr_q] = 1'b0;
          left_d          = left_q - 6'd1;
          hrect_d         = desc;
          hbx_d           = !cur_in_x;
          hby_d           = cur_in_x || !cur_in_y;
        end
        if (addr_q == LAST_ADDR) begin
          if (found_d) begin
            state_d     = S_ERASE;
            paint_start = 1'b1;
            paint_rect  = hrect_d;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_ERASE: if (paint_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
`ifdef INIT_PAINT_EN
      S_PFETCH: state_d = S_PWAIT;
      S_PWAIT: begin
        paint_start = 1'b1;
        paint_rect  = desc;
        paint_color = addr_q[2:0] | 3'b001;
        state_d     = S_PAINT;
      end
      S_PAINT: begin
        if (paint_done) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_PFETCH;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      alive_q <= '1;
      left_q  <= 6'(NUM_BRICKS);
      pend_q  <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      oob_q   <= 1'b0;
      found_q <= 1'b0;
      hrect_q <= '0;
      hbx_q   <= 1'b0;
      hby_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      alive_q <= alive_d;
      left_q  <= left_d;
      pend_q  <= pend_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      oob_q   <= oob_d;
      found_q <= found_d;
      hrect_q <= hrect_d;
      hbx_q   <= hbx_d;
      hby_q   <= hby_d;
    end
  end

  rect_painter #(.RESET_COLOR(ERASE_COLOR)) u_painter (
    .clock      (clock),
    .reset      (reset),
    .start      (paint_start),
    .x          (paint_rect.x),
    .y          (paint_rect.y),
    .w          (paint_rect.w),
    .h          (paint_rect.h),
    .color      (paint_color),
    .draw_ack   (draw_ack),
    .draw_req   (draw_req),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_color (draw_color),
    .done       (paint_done)
  );

  assign rd_addr     = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign bounce_x    = (state_q == S_DONE) && hbx_q;
  assign bounce_y    = (state_q == S_DONE) && hby_q;
  assign bricks_left = left_q;
  assign all_clear   = (left_q == 6'd0);
endmodule
